// File: rtl/alu_pkg.sv
// Shared definitions for the ALU exception unit: op codes, status bit indices,
// exception cause encoding and the handshake FSM state type.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_DIV = 4'b1001;

  localparam int ST_ZERO  = 7;
  localparam int ST_OVF   = 6;
  localparam int ST_CARRY = 5;
  localparam int ST_NEG   = 4;
  localparam int ST_ODD   = 3;
  localparam int ST_DZ    = 2;

  // Only overflow, carry and div-by-zero accumulate; reserved bits never captured.
  localparam logic [7:0] STICKY_MASK  = 8'h64;
  localparam logic [7:0] CAPTURE_MASK = 8'hFC;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_OVF   = 2'd1,
    CAUSE_DZ    = 2'd2,
    CAUSE_CARRY = 2'd3
  } cause_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/alu_exc_if.sv
// ALU-status input bus and the exception req/ack link to the control unit.
// exc_req is held high until exc_ack is seen high on a rising edge; ack outside REQ is ignored.
interface alu_exc_if #(
  parameter int PC_W = 32
);
  logic            alu_valid;
  logic [3:0]      alu_ctrl;
  logic [7:0]      alu_status;
  logic [PC_W-1:0] pc;
  logic            exc_ack;
  logic            exc_req;
  logic [1:0]      exc_cause;
  logic [PC_W-1:0] exc_epc;

  modport master (
    output alu_valid, alu_ctrl, alu_status, pc, exc_ack,
    input  exc_req, exc_cause, exc_epc
  );

  modport slave (
    input  alu_valid, alu_ctrl, alu_status, pc, exc_ack,
    output exc_req, exc_cause, exc_epc
  );
endinterface

// File: rtl/alu_exc_detect.sv
// Combinational exception cause encoder, priority dz > ov (> carry).
// Carry exceptions exist only when ALU_EXC_CARRY_EN is defined.
module alu_exc_detect
  import alu_pkg::*;
(
  input  logic [3:0] alu_ctrl,
  input  logic [7:0] alu_status,
  input  logic       ovf_en,
  output cause_t     cause
);
  logic dz;
  logic ov;

  assign dz = alu_status[ST_DZ] && (alu_ctrl == ALU_DIV);
  assign ov = alu_status[ST_OVF] && ovf_en &&
              ((alu_ctrl == ALU_ADD) || (alu_ctrl == ALU_SUB) || (alu_ctrl == ALU_MUL));

  always_comb begin
    cause = CAUSE_NONE;
`ifdef ALU_EXC_CARRY_EN
    if (alu_status[ST_CARRY] && (alu_ctrl == ALU_ADD)) cause = CAUSE_CARRY;
`endif
    if (ov) cause = CAUSE_OVF;
    if (dz) cause = CAUSE_DZ;
  end
endmodule

// File: rtl/alu_exception_unit.sv
// EX-stage ALU exception unit: status capture, sticky flags, exception req/ack FSM and stall.
// Optional carry exceptions are enabled with the ALU_EXC_CARRY_EN macro.
module alu_exception_unit
  import alu_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_exc_if.slave         bus,
  input  logic             ovf_en,
  input  logic             sticky_clr,
  output logic [7:0]       status_q,
  output logic [7:0]       sticky_q,
  output logic             stall,
  output logic [CNT_W-1:0] exc_cnt,
  output state_t           state
);
  cause_t det_cause;
  logic   capture;

  alu_exc_detect u_detect (
    .alu_ctrl   (bus.alu_ctrl),
    .alu_status (bus.alu_status),
    .ovf_en     (ovf_en),
    .cause      (det_cause)
  );

  assign capture = (state == IDLE) && bus.alu_valid;
  assign stall   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      status_q      <= '0;
      sticky_q      <= '0;
      exc_cnt       <= '0;
      bus.exc_req   <= 1'b0;
      bus.exc_cause <= CAUSE_NONE;
      bus.exc_epc   <= '0;
    end else begin
      // A capture's new bits take precedence over a same-cycle clear.
      if (capture) begin
        status_q <= bus.alu_status & CAPTURE_MASK;
        sticky_q <= (sticky_clr ? 8'h00 : sticky_q) | (bus.alu_status & STICKY_MASK);
      end else if (sticky_clr) begin
        sticky_q <= '0;
      end

      case (state)
        IDLE: begin
          if (capture && (det_cause != CAUSE_NONE)) begin
            state         <= REQ;
            bus.exc_req   <= 1'b1;
            bus.exc_cause <= det_cause;
            bus.exc_epc   <= bus.pc;
            if (exc_cnt != {CNT_W{1'b1}}) exc_cnt <= exc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        REQ: begin
          if (bus.exc_ack) begin
            state       <= DRAIN;
            bus.exc_req <= 1'b0;
          end
        end
        DRAIN: begin
          state         <= IDLE;
          bus.exc_cause <= CAUSE_NONE;
        end
        default: begin
          state       <= IDLE;
          bus.exc_req <= 1'b0;
        end
      endcase
    end
  end
endmodule
